// File: rtl/video_pix_packer64.sv
// Packs a 24-bit RGB pixel stream into 64-bit little-endian words, tagged with
// start-of-frame / end-of-line flags and buffered in a first-word-fall-through FIFO.
module video_pix_packer64 #(
  parameter int FIFO_DEPTH = 8,
  parameter bit REVERSE64  = 1'b0
) (
  input  logic                          px_clk,
  input  logic                          rst,
  input  logic                          vsync,
  input  logic                          dval,
  input  logic [23:0]                   px_data,
  output logic [63:0]                   wr_data,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic                          wr_sof,
  output logic                          wr_eol,
  output logic                          overflow,
  output logic [15:0]                   frame_lines,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [63:0] data;
  } entry_t;

  function automatic logic [63:0] swap64(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(7-i) +: 8];
    return r;
  endfunction

  logic          vsync_q, vsync_qq, dval_q;
  logic [23:0]   px_q;
  logic [2:0]    pix_idx, pix_idx_nx;
  logic [191:0]  acc, acc_nx, acc_ins;
  logic          flush_pend, flush_nx;
  logic          sof_pending;
  logic [15:0]   line_cnt;
  logic          frame_start, last_px;
  logic          stg_load, stg_eol;
  logic [63:0]   stg_word;
  logic          stg_valid;
  entry_t        stg;
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, pop, push;

  assign frame_start = vsync_q & ~vsync_qq;
  assign last_px     = dval_q & ~dval;

  // pix_idx is the slot the registered pixel lands in; word k of the group is acc[64k +: 64].
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_ins = acc;
    for (int i = 0; i < 8; i++)
      if (pix_idx == 3'(i)) acc_ins[24*i +: 24] = px_q;
    acc_nx     = acc;
    pix_idx_nx = pix_idx;
    flush_nx   = flush_pend;
    stg_load   = 1'b0;
    stg_word   = '0;
    stg_eol    = 1'b0;
    if (frame_start) begin
      acc_nx     = '0;
      pix_idx_nx = '0;
      flush_nx   = 1'b0;
    end else if (dval_q) begin
      acc_nx     = acc_ins;
      pix_idx_nx = pix_idx + 3'd1;
      case (pix_idx)
        3'd2: begin stg_load = 1'b1; stg_word = acc_ins[63:0];   end
        3'd5: begin stg_load = 1'b1; stg_word = acc_ins[127:64]; end
        3'd7: begin stg_load = 1'b1; stg_word = acc_ins[191:128]; acc_nx = '0; end
        default: ;
      endcase
      if (last_px) begin
        if (pix_idx == 3'd7) stg_eol  = 1'b1;
        else                 flush_nx = 1'b1;
      end
    end else if (flush_pend) begin
      // Upper bits of the partial word are already zero: acc is cleared per group.
      stg_load   = 1'b1;
      stg_eol    = 1'b1;
      acc_nx     = '0;
      pix_idx_nx = '0;
      flush_nx   = 1'b0;
      case (pix_idx)
        3'd1, 3'd2:       stg_word = acc[63:0];
        3'd3, 3'd4, 3'd5: stg_word = acc[127:64];
        default:          stg_word = acc[191:128];
      endcase
    end
  end

  assign wr_valid = (level != '0);
  assign full     = (level == LW'(FIFO_DEPTH));
  assign pop      = wr_valid & wr_ready;
  assign push     = stg_valid & (~full | pop);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      vsync_qq    <= 1'b0;
      dval_q      <= 1'b0;
      px_q        <= '0;
      acc         <= '0;
      pix_idx     <= '0;
      flush_pend  <= 1'b0;
      stg_valid   <= 1'b0;
      stg         <= '0;
      sof_pending <= 1'b0;
      line_cnt    <= '0;
      frame_lines <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow    <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      vsync_qq   <= vsync_q;
      dval_q     <= dval;
      px_q       <= px_data;
      acc        <= acc_nx;
      pix_idx    <= pix_idx_nx;
      flush_pend <= flush_nx;
      stg_valid  <= stg_load;
      if (stg_load) begin
        stg.sof  <= sof_pending;
        stg.eol  <= stg_eol;
        stg.data <= REVERSE64 ? swap64(stg_word) : stg_word;
      end
      if (frame_start)   sof_pending <= 1'b1;
      else if (stg_load) sof_pending <= 1'b0;
      if (frame_start) begin
        frame_lines <= line_cnt;
        line_cnt    <= '0;
      end else if (last_px && line_cnt != 16'hFFFF) begin
        line_cnt <= line_cnt + 16'd1;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
      if (stg_valid && full && !pop) overflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge px_clk) begin
    if (push) mem[wr_ptr] <= stg;
  end

  assign wr_data    = wr_valid ? mem[rd_ptr].data : '0;
  assign wr_sof     = wr_valid & mem[rd_ptr].sof;
  assign wr_eol     = wr_valid & mem[rd_ptr].eol;
  assign fifo_level = level;

endmodule

// File: tb/tb_video_pix_packer64.sv
// Bench for video_pix_packer64: random pixel lines checked against a byte-stream
// model of the packing rules, plus directed latency, overflow, reverse and reset cases.
module tb_video_pix_packer64;

  logic        px_clk = 1'b0;
  logic        rst = 1'b1, vsync = 1'b0, dval = 1'b0;
  logic [23:0] px_data = '0;
  logic        ready = 1'b0, r_ready = 1'b0;

  logic [63:0] wr_data, r_wr_data;
  logic        wr_valid, wr_sof, wr_eol, overflow;
  logic        r_wr_valid, r_wr_sof, r_wr_eol, r_overflow;
  logic [15:0] frame_lines, r_frame_lines;
  logic [3:0]  fifo_level, r_fifo_level;

  video_pix_packer64 #(.FIFO_DEPTH(8), .REVERSE64(1'b0)) dut (
    .px_clk(px_clk), .rst(rst), .vsync(vsync), .dval(dval), .px_data(px_data),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(ready), .wr_sof(wr_sof),
    .wr_eol(wr_eol), .overflow(overflow), .frame_lines(frame_lines), .fifo_level(fifo_level));

  video_pix_packer64 #(.FIFO_DEPTH(8), .REVERSE64(1'b1)) dut_rev (
    .px_clk(px_clk), .rst(rst), .vsync(vsync), .dval(dval), .px_data(px_data),
    .wr_data(r_wr_data), .wr_valid(r_wr_valid), .wr_ready(r_ready), .wr_sof(r_wr_sof),
    .wr_eol(r_wr_eol), .overflow(r_overflow), .frame_lines(r_frame_lines),
    .fifo_level(r_fifo_level));

  always #5 px_clk = ~px_clk;

  typedef struct {
    logic [63:0] data;
    bit          sof;
    bit          eol;
  } word_t;

  word_t       exp_q[$];
  logic [23:0] line_px[$];
  int          tests = 0, fails = 0;
  int          rx_cnt = 0, rx0;
  logic [63:0] last_rx = '0;
  bit          m_sof_pend = 1'b0;
  int          m_lines = 0;
  bit          rand_rdy = 1'b0;
  localparam int KEEP_ALL = 1 << 30;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Consumer side: a transfer seen here completes on the next rising edge.
  always @(negedge px_clk) begin
    word_t e;
    if (!rst && wr_valid && ready) begin
      check("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_data", wr_data, e.data);
        check("wr_sof", 64'(wr_sof), 64'(e.sof));
        check("wr_eol", 64'(wr_eol), 64'(e.eol));
      end
      rx_cnt++;
      last_rx = wr_data;
    end
  end

  // Line model: pixels become a little-endian byte stream chopped into 8-byte words.
  task automatic model_line(input int first, input int n, input bit whole, input int keep);
    logic [7:0] bytes[$];
    int nb, nw;
    for (int i = first; i < first + n; i++) begin
      bytes.push_back(line_px[i][7:0]);
      bytes.push_back(line_px[i][15:8]);
      bytes.push_back(line_px[i][23:16]);
    end
    nb = bytes.size();
    nw = whole ? (nb + 7) / 8 : nb / 8;
    for (int w = 0; w < nw; w++) begin
      word_t e;
      e.data = '0;
      for (int j = 0; j < 8; j++)
        if (8 * w + j < nb) e.data[8*j +: 8] = bytes[8*w + j];
      e.sof = m_sof_pend && (w == 0);
      e.eol = whole && (w == nw - 1);
      if (w < keep) exp_q.push_back(e);
    end
    if (nw > 0) m_sof_pend = 1'b0;
  endtask

  task automatic drive(input logic v, input logic d, input logic [23:0] pd);
    vsync = v;
    dval = d;
    px_data = pd;
    if (rand_rdy) ready = ($urandom_range(0, 3) != 0);
    @(posedge px_clk);
    #1;
  endtask

  task automatic send_line(input int n, input int keep);
    line_px.delete();
    for (int i = 0; i < n; i++) line_px.push_back(24'($urandom));
    model_line(0, n, 1'b1, keep);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, line_px[i]);
    repeat (10) drive(1'b0, 1'b0, 24'h0);
    m_lines++;
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    rand_rdy = 1'b0;
    ready = 1'b1;
    while ((exp_q.size() != 0 || fifo_level != 4'd0) && c < 3000) begin
      @(posedge px_clk);
      #1;
      c++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_vsync();
    int exp_fl = m_lines;
    m_lines = 0;
    m_sof_pend = 1'b1;
    repeat (3) drive(1'b1, 1'b0, 24'h0);
    repeat (3) drive(1'b0, 1'b0, 24'h0);
    check("frame_lines", 64'(frame_lines), 64'(exp_fl));
    check("rev_frame_lines", 64'(r_frame_lines), 64'(exp_fl));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_valid"}, 64'(wr_valid), 64'd0);
    check({tag, "_wr_data"}, wr_data, 64'd0);
    check({tag, "_wr_sof"}, 64'(wr_sof), 64'd0);
    check({tag, "_wr_eol"}, 64'(wr_eol), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_frame_lines"}, 64'(frame_lines), 64'd0);
    check({tag, "_fifo_level"}, 64'(fifo_level), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge px_clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    drive(1'b0, 1'b0, 24'h0);

    // Pixels 1..8, no frame sync yet: three words, eol on the third, no flush word
    ready = 1'b1;
    r_ready = 1'b0;
    rx0 = rx_cnt;
    exp_q.push_back('{64'h0003000002000001, 1'b0, 1'b0});
    exp_q.push_back('{64'h0600000500000400, 1'b0, 1'b0});
    exp_q.push_back('{64'h0000080000070000, 1'b0, 1'b1});
    drive(1'b0, 1'b1, 24'd1);
    drive(1'b0, 1'b1, 24'd2);
    drive(1'b0, 1'b1, 24'd3);
    drive(1'b0, 1'b1, 24'd4);
    check("latency_early", 64'(wr_valid), 64'd0);
    drive(1'b0, 1'b1, 24'd5);
    check("latency_valid", 64'(wr_valid), 64'd1);
    check("latency_head", wr_data, 64'h0003000002000001);
    drive(1'b0, 1'b1, 24'd6);
    drive(1'b0, 1'b1, 24'd7);
    drive(1'b0, 1'b1, 24'd8);
    repeat (10) drive(1'b0, 1'b0, 24'h0);
    m_lines++;
    check("rev_level", 64'(r_fifo_level), 64'd3);
    check("rev_head", r_wr_data, 64'h0100000200000300);
    check("rev_head_sof", 64'(r_wr_sof), 64'd0);
    check("rev_head_eol", 64'(r_wr_eol), 64'd0);
    r_ready = 1'b1;
    wait_drain("t1_drain");
    check("t1_words", 64'(rx_cnt - rx0), 64'd3);

    // Full frame: 3 lines of 1080 pixels, consumer always ready
    pulse_vsync();
    rx0 = rx_cnt;
    repeat (3) send_line(1080, KEEP_ALL);
    wait_drain("t3_drain");
    check("t3_words", 64'(rx_cnt - rx0), 64'd1215);
    pulse_vsync();

    // 10-pixel line with a stalling consumer: fourth word holds pixels 8,9 zero-padded
    rand_rdy = 1'b1;
    rx0 = rx_cnt;
    send_line(10, KEEP_ALL);
    wait_drain("t4_drain");
    check("t4_words", 64'(rx_cnt - rx0), 64'd4);
    check("t4_pad", 64'(last_rx[63:48]), 64'd0);
    check("t4_px89", 64'(last_rx[47:0]), 64'({line_px[9], line_px[8]}));

    // Random short lines, random backpressure
    for (int k = 0; k < 6; k++) begin
      rand_rdy = 1'b1;
      send_line($urandom_range(1, 40), KEEP_ALL);
    end
    wait_drain("rand_drain");

    // Overflow: consumer stalled for a whole line, only the first 8 words survive
    rand_rdy = 1'b0;
    ready = 1'b0;
    rx0 = rx_cnt;
    send_line(1080, 8);
    check("ovf_level", 64'(fifo_level), 64'd8);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_valid", 64'(wr_valid), 64'd1);
    wait_drain("ovf_drain");
    check("ovf_words", 64'(rx_cnt - rx0), 64'd8);
    check("ovf_sticky", 64'(overflow), 64'd1);
    pulse_vsync();

    // Reset at pixel 500 of a line; rest of the line packs without sof
    rand_rdy = 1'b1;
    line_px.delete();
    for (int i = 0; i < 1080; i++) line_px.push_back(24'($urandom));
    model_line(0, 500, 1'b0, KEEP_ALL);
    for (int i = 0; i < 500; i++) drive(1'b0, 1'b1, line_px[i]);
    rst = 1'b1;
    drive(1'b0, 1'b1, line_px[500]);
    rst = 1'b0;
    exp_q.delete();
    m_sof_pend = 1'b0;
    m_lines = 0;
    check_all_zero("midline_rst");
    model_line(501, 579, 1'b1, KEEP_ALL);
    for (int i = 501; i < 1080; i++) drive(1'b0, 1'b1, line_px[i]);
    repeat (10) drive(1'b0, 1'b0, 24'h0);
    m_lines++;
    wait_drain("rst_line_drain");
    pulse_vsync();
    rand_rdy = 1'b1;
    send_line(16, KEEP_ALL);
    wait_drain("post_rst_frame_drain");
    check("rev_no_overflow", 64'(r_overflow), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
